// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// IJTAG-side controller for the gate1 19-bit functional/IJTAG data mux: scannable TDR plus a
// safe select sequencer. Optional ARM timeout is enabled by FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN.
module firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(
    parameter int unsigned W              = 19,
    parameter int unsigned QUIET_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         ijtag_tck,
    input  logic         ijtag_reset,
    input  logic         ijtag_sel,
    input  logic         ijtag_ce,
    input  logic         ijtag_se,
    input  logic         ijtag_ue,
    input  logic         ijtag_si,
    output logic         ijtag_so,
    input  logic         func_idle,
    input  logic [W-1:0] data_observe,
    output logic         ijtag_select,
    output logic [W-1:0] ijtag_data,
    output logic         busy,
    output logic         timeout_flag
);

    localparam int unsigned CntMaxQs = (QUIET_CYCLES > SETTLE_CYCLES) ? QUIET_CYCLES
                                                                      : SETTLE_CYCLES;
    localparam int unsigned CntMax   = (CntMaxQs > TIMEOUT_CYCLES) ? CntMaxQs : TIMEOUT_CYCLES;
    localparam int unsigned CntW     = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [1:0] StFunc  = 2'd0;
    localparam logic [1:0] StArm   = 2'd1;
    localparam logic [1:0] StTest  = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    logic [W:0]      sr_q, sr_d;
    logic [W-1:0]    shadow_q, shadow_d;
    logic            req_q, req_d;
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            flag_clr;
    logic            tmo_hit;

    // TDR: capture beats shift beats update
    always_comb begin
        sr_d     = sr_q;
        shadow_d = shadow_q;
        req_d    = req_q;
        flag_clr = 1'b0;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_d     = {ijtag_select, data_observe};
                flag_clr = 1'b1;
            end else if (ijtag_se) begin
                sr_d = {ijtag_si, sr_q[W:1]};
            end else if (ijtag_ue) begin
                shadow_d = sr_q[W-1:0];
                req_d    = sr_q[W];
            end
        end
    end

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CntW'(1);

`ifdef FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN
    logic [CntW-1:0] tcnt_q, tcnt_d, tcnt_inc;
    logic            flag_q, flag_d;

    assign tcnt_inc = (&tcnt_q) ? tcnt_q : tcnt_q + CntW'(1);
    assign tcnt_d   = (state_q == StArm) ? tcnt_inc : '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_hit = 1'b0;
        case (state_q)
            StFunc: begin
                if (req_q) begin
                    state_d = StArm;
                    cnt_d   = '0;
                end
            end
            StArm: begin
                if (!req_q) begin
                    state_d = StFunc;
                end else if (func_idle) begin
                    if (cnt_q == CntW'(QUIET_CYCLES - 1)) state_d = StTest;
                    else                                  cnt_d   = cnt_inc;
                end else begin
                    cnt_d = '0;
                end
`ifdef FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN
                // A quiet-count exit on the same cycle takes precedence and leaves the flag alone
                if (req_q && state_d == StArm && tcnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StTest;
                    tmo_hit = 1'b1;
                end
`endif
            end
            StTest: begin
                if (!req_q) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == CntW'(SETTLE_CYCLES - 1)) state_d = StFunc;
                else                                   cnt_d   = cnt_inc;
            end
        endcase
    end

`ifdef FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN
    always_comb begin
        flag_d = flag_q;
        if (tmo_hit)       flag_d = 1'b1;
        else if (flag_clr) flag_d = 1'b0;
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            tcnt_q <= '0;
            flag_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            flag_q <= flag_d;
        end
    end

    assign timeout_flag = flag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sr_q     <= '0;
            shadow_q <= '0;
            req_q    <= 1'b0;
            state_q  <= StFunc;
            cnt_q    <= '0;
        end else begin
            sr_q     <= sr_d;
            shadow_q <= shadow_d;
            req_q    <= req_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ijtag_so     = sr_q[0];
    assign ijtag_select = (state_q == StTest);
    assign ijtag_data   = shadow_q;
    assign busy         = (state_q == StArm) || (state_q == StDrain);

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// Bench for the gate1 data mux controller: table vectors, directed corner sequences and a
// randomized run against a behavioural model.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19;

    localparam int W       = 19;
    localparam int QUIET   = 4;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 16;

    logic         tck = 1'b0;
    logic         rst, sel, ce, se, ue, si, idle;
    logic [W-1:0] obs;
    logic         so, select, busy, flag;
    logic [W-1:0] data;

    firebird7_in_gate1_tessent_data_mux_ctrl_w19 dut (
        .ijtag_tck    (tck),
        .ijtag_reset  (rst),
        .ijtag_sel    (sel),
        .ijtag_ce     (ce),
        .ijtag_se     (se),
        .ijtag_ue     (ue),
        .ijtag_si     (si),
        .ijtag_so     (so),
        .func_idle    (idle),
        .data_observe (obs),
        .ijtag_select (select),
        .ijtag_data   (data),
        .busy         (busy),
        .timeout_flag (flag)
    );

    always #5 tck = ~tck;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic shift_word(input logic [19:0] w, output logic [19:0] got);
        se = 1'b1;
        for (int i = 0; i < 20; i++) begin
            si     = w[i];
            got[i] = so;
            tick();
        end
        se = 1'b0;
        si = 1'b0;
    endtask

    task automatic update();
        ue = 1'b1;
        tick();
        ue = 1'b0;
    endtask

    task automatic capture();
        ce = 1'b1;
        tick();
        ce = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Behavioural model: sequencing tracked as idle-run length, ARM age and drain time left
    logic [19:0]  m_sr;
    logic [W-1:0] m_shadow;
    bit m_req, m_sel, m_arming, m_flag;
    int m_drain_left, m_idle_run, m_arm_age;

    task automatic model_clear();
        m_sr = '0; m_shadow = '0; m_req = 0; m_sel = 0; m_arming = 0; m_flag = 0;
        m_drain_left = 0; m_idle_run = 0; m_arm_age = 0;
    endtask

    task automatic model_step();
        bit old_sel, old_req, tmo;
        if (rst) begin
            model_clear();
            return;
        end
        old_sel = m_sel;
        old_req = m_req;
        tmo     = 0;
        if (sel) begin
            if (ce) m_sr = {old_sel, obs};
            else if (se) m_sr = {si, m_sr[19:1]};
            else if (ue) begin
                m_shadow = m_sr[W-1:0];
                m_req    = m_sr[W];
            end
        end
        if (old_sel) begin
            if (!old_req) begin
                m_sel        = 0;
                m_drain_left = SETTLE;
            end
        end else if (m_drain_left > 0) begin
            m_drain_left--;
        end else if (m_arming) begin
            if (!old_req) m_arming = 0;
            else begin
                m_arm_age++;
                m_idle_run = idle ? m_idle_run + 1 : 0;
                if (m_idle_run >= QUIET) begin
                    m_arming = 0;
                    m_sel    = 1;
                end
`ifdef FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN
                else if (m_arm_age >= TIMEOUT) begin
                    m_arming = 0;
                    m_sel    = 1;
                    tmo      = 1;
                end
`endif
            end
        end else if (old_req) begin
            m_arming   = 1;
            m_idle_run = 0;
            m_arm_age  = 0;
        end
`ifdef FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN
        if (tmo) m_flag = 1;
        else if (sel && ce) m_flag = 0;
`endif
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] obs;
        logic [W-1:0] exp_data;
        logic [19:0]  exp_cap;
    } vec_t;

    vec_t        vt[4];
    logic [19:0] got;
    bit          pat[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0] = '{19'h00001, 19'h40000, 19'h00001, 20'h40000};
        vt[1] = '{19'h7FFFF, 19'h2AAAA, 19'h7FFFF, 20'h2AAAA};
        vt[2] = '{19'h5A5A5, 19'h00000, 19'h5A5A5, 20'h00000};
        vt[3] = '{19'h13579, 19'h7FFFF, 19'h13579, 20'h7FFFF};
        pat   = '{1, 1, 0, 1, 1, 1, 1};

        rst = 1'b1; sel = 1'b1; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
        idle = 1'b0; obs = '0;

        // Reset state
        do_reset();
        chk("rst_select", select, 0);
        chk("rst_data", data, 0);
        chk("rst_so", so, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flag", flag, 0);

        // Load/capture vectors with req=0: select stays low, capture returns {0, obs}
        for (int i = 0; i < 4; i++) begin
            shift_word({1'b0, vt[i].data}, got);
            update();
            chk("tbl_data", data, vt[i].exp_data);
            chk("tbl_busy", busy, 0);
            obs = vt[i].obs;
            capture();
            shift_word(20'h0, got);
            chk("tbl_capture", got, vt[i].exp_cap);
        end

        // Request with idle source: select 4 cycles after ARM entry
        idle = 1'b1;
        shift_word({1'b1, 19'h5A5A5}, got);
        update();
        chk("req_data", data, 19'h5A5A5);
        chk("req_busy_func", busy, 0);
        tick();
        chk("arm_busy", busy, 1);
        repeat (3) tick();
        chk("arm_sel_early", select, 0);
        tick();
        chk("arm_sel_rise", select, 1);

        // Idle gap restarts the quiet count
        do_reset();
        idle = 1'b0;
        shift_word({1'b1, 19'h0ABCD}, got);
        update();
        tick();
        for (int k = 0; k < 7; k++) begin
            idle = pat[k];
            tick();
            chk("gap_select", select, (k == 6));
        end

        // Update with req=1 in TEST only reloads data
        shift_word({1'b1, 19'h01111}, got);
        update();
        chk("test_reload_data", data, 19'h01111);
        tick();
        chk("test_reload_sel", select, 1);

        // Drop request, then re-request during DRAIN
        shift_word({1'b0, 19'h12345}, got);
        update();
        chk("drop_sel_hold", select, 1);
        se = 1'b1; si = 1'b1;
        tick();
        se = 1'b0; si = 1'b0;
        chk("drain_sel", select, 0);
        chk("drain_busy1", busy, 1);
        update();
        chk("drain_busy2", busy, 1);
        chk("drain_sel2", select, 0);
        chk("drain_data", data, 19'h091A2);
        tick();
        chk("drain_func", busy, 0);
        tick();
        chk("rearm_busy", busy, 1);
        for (int k = 0; k < 20 && !select; k++) tick();
        chk("rearm_reach_test", select, 1);

        // Capture in TEST reads select back as the top bit
        obs = 19'h7FFFF;
        capture();
        shift_word(20'h0, got);
        chk("test_capture", got, 20'hFFFFF);

        // ARM with a busy functional side
        do_reset();
        idle = 1'b0;
        shift_word({1'b1, 19'h0}, got);
        update();
        tick();
        repeat (15) tick();
        chk("tmo_sel_early", select, 0);
        chk("tmo_busy_early", busy, 1);
        tick();
`ifdef FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN
        chk("tmo_select", select, 1);
        chk("tmo_flag", flag, 1);
        tick();
        chk("tmo_flag_sticky", flag, 1);
        capture();
        chk("tmo_flag_clr", flag, 0);
`else
        chk("notmo_select", select, 0);
        chk("notmo_flag", flag, 0);
        repeat (20) tick();
        chk("notmo_still_arm", busy, 1);
        chk("notmo_select2", select, 0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_select", select, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", data, 0);

        // Randomized run against the model
        do_reset();
        model_clear();
        for (int seg = 0; seg < 15; seg++) begin
            int unsigned p_idle;
            p_idle = (seg % 3 == 0) ? 95 : ((seg % 3 == 1) ? 60 : 10);
            for (int c = 0; c < 200; c++) begin
                rst  = ($urandom_range(255) == 0);
                sel  = ($urandom_range(7) != 0);
                ce   = ($urandom_range(31) == 0);
                se   = ($urandom_range(1) == 0);
                ue   = ($urandom_range(7) == 0);
                si   = 1'($urandom_range(1));
                idle = ($urandom_range(99) < p_idle);
                obs  = W'($urandom);
                @(posedge tck);
                model_step();
                #1;
                chk("rnd_so", so, m_sr[0]);
                chk("rnd_select", select, m_sel);
                chk("rnd_data", data, m_shadow);
                chk("rnd_busy", busy, m_arming || (m_drain_left > 0));
                chk("rnd_flag", flag, m_flag);
            end
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
